alu_arbiter: RTL and testbench

Shares one instance of the MIPS32 ALU datapath between two requesters, for example the main execute stage and a branch/address helper unit. It accepts one operation at a time through a per-port valid/ready handshake and selects the port round-robin. Operands are latched, the ALU runs for one cycle, and the result plus zero flag are returned on a shared, registered response bus tagged with the requester id. The block sits between the requesters and the combinational ALU and owns all sequencing of it.

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Function : Two-port valid/ready arbiter around a shared single-cycle ALU;
//            round-robin by default, fixed priority when ALU_ARB_FIXED_PRIO_EN
//            is defined.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int SIZEDATA = 32,
    parameter int OP       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*SIZEDATA-1:0] req_a,
    input  logic [2*SIZEDATA-1:0] req_b,
    input  logic [2*OP-1:0]       req_op,
    output logic                  rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic                  rsp_id,
    output logic [SIZEDATA-1:0]   rsp_result,
    output logic                  rsp_zero,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          grant;
    logic [SIZEDATA-1:0] op_a;
    logic [SIZEDATA-1:0] op_b;
    logic [OP-1:0]       op_code;
    logic                op_id;
    logic [SIZEDATA-1:0] alu_result;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`else
    logic last_grant;

    // Contention goes to the port that did not win last time.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (state == S_RESP && rsp_ready[rsp_id])
            last_grant <= rsp_id;
    end
`endif

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            S_IDLE: begin
                req_ready = reset ? 2'b00 : grant;
                if (grant != 2'b00)
                    state_nxt = S_EXEC;
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready[rsp_id])
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (op_code)
            4'b0000: alu_result = op_a & op_b;
            4'b0001: alu_result = op_a | op_b;
            4'b0010: alu_result = op_a + op_b;
            4'b0110: alu_result = op_a - op_b;
            4'b0111: alu_result = {{(SIZEDATA-1){1'b0}}, (op_a < op_b)};
            4'b1100: alu_result = ~(op_a | op_b);
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && grant != 2'b00) begin
                op_id   <= grant[1];
                op_a    <= grant[1] ? req_a[2*SIZEDATA-1:SIZEDATA] : req_a[SIZEDATA-1:0];
                op_b    <= grant[1] ? req_b[2*SIZEDATA-1:SIZEDATA] : req_b[SIZEDATA-1:0];
                op_code <= grant[1] ? req_op[2*OP-1:OP] : req_op[OP-1:0];
            end
            if (state == S_EXEC) begin
                rsp_id     <= op_id;
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == '0);
            end
        end
    end

    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Function : Directed self-checking bench for alu_arbiter.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic [1:0]  rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        busy;

    int cmps = 0;
    int errs = 0;

    alu_arbiter #(.SIZEDATA(32), .OP(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation on a single port, collect and acknowledge it.
    task automatic run_op(input string tag, input int port, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] exp_res);
        int n;
        if (port == 0) begin
            req_a[31:0] = a; req_b[31:0] = b; req_op[3:0] = op;
        end else begin
            req_a[63:32] = a; req_b[63:32] = b; req_op[7:4] = op;
        end
        req_valid = (port == 0) ? 2'b01 : 2'b10;
        #1;
        n = 0;
        while (req_ready[port] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check({tag, "_granted"}, {63'd0, req_ready[port]}, 64'd1);
        step();
        req_valid = 2'b00;
        check({tag, "_exec_rdy"}, {62'd0, req_ready}, 64'd0);
        check({tag, "_exec_vld"}, {63'd0, rsp_valid}, 64'd0);
        step();
        check({tag, "_vld"},  {63'd0, rsp_valid}, 64'd1);
        check({tag, "_id"},   {63'd0, rsp_id}, 64'(port));
        check({tag, "_res"},  {32'd0, rsp_result}, {32'd0, exp_res});
        check({tag, "_zero"}, {63'd0, rsp_zero}, {63'd0, (exp_res == 32'd0)});
        rsp_ready = (port == 0) ? 2'b01 : 2'b10;
        step();
        rsp_ready = 2'b00;
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int exp_ids[4];
        int n;
        logic [31:0] hold_res;

        reset = 1'b1; req_valid = 2'b01; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        #1;
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_ready", {62'd0, req_ready}, 64'd0);
        check("rst_res",   {32'd0, rsp_result}, 64'd0);
        req_valid = 2'b00;
        #12 reset = 1'b0;
        step();

        run_op("add5_7",   0, 32'd5,          32'd7,  4'b0010, 32'd12);
        run_op("sub9_9",   1, 32'd9,          32'd9,  4'b0110, 32'd0);
        run_op("sub0_1",   0, 32'd0,          32'd1,  4'b0110, 32'hFFFF_FFFF);
        run_op("addwrap",  1, 32'hFFFF_FFFF,  32'd1,  4'b0010, 32'd0);
        run_op("slt_uns",  0, 32'h8000_0000,  32'd1,  4'b0111, 32'd0);
        run_op("slt_lt",   1, 32'd1,          32'd2,  4'b0111, 32'd1);
        run_op("nor00",    0, 32'd0,          32'd0,  4'b1100, 32'hFFFF_FFFF);
        run_op("and",      1, 32'hF0F0_1234,  32'h0FF0_FF00, 4'b0000, 32'h00F0_1200);
        run_op("or",       0, 32'hF000_0001,  32'h0000_0100, 4'b0001, 32'hF000_0101);
        run_op("badop",    1, 32'd3,          32'd4,  4'b0011, 32'd0);

        // Contention: reset so the pointer starts at 1.
        reset = 1'b1; #3 reset = 1'b0;
        step();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 0, 1};
`endif
        req_a = {32'd10, 32'd1}; req_b = {32'd1, 32'd1}; req_op = 8'h22;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            check($sformatf("rr_vld%0d", k), {63'd0, rsp_valid}, 64'd1);
            check($sformatf("rr_id%0d", k), {63'd0, rsp_id}, 64'(exp_ids[k]));
            check($sformatf("rr_res%0d", k), {32'd0, rsp_result},
                  (exp_ids[k] == 0) ? 64'd2 : 64'd11);
            check($sformatf("rr_rsprdy%0d", k), {62'd0, req_ready}, 64'd0);
            step();
            check($sformatf("rr_idle%0d", k), {63'd0, busy}, 64'd0);
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        step(); step(); step();

        // Backpressure on a port-1 response.
        req_a[63:32] = 32'd0; req_b[63:32] = 32'd1; req_op[7:4] = 4'b0110;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        hold_res = rsp_result;
        check("bp_res", {32'd0, hold_res}, 64'h0000_0000_FFFF_FFFF);
        req_valid = 2'b01;
        for (int k = 0; k < 5; k++) step();
        check("bp_vld",   {63'd0, rsp_valid}, 64'd1);
        check("bp_hold",  {32'd0, rsp_result}, {32'd0, hold_res});
        check("bp_rdy",   {62'd0, req_ready}, 64'd0);
        rsp_ready = 2'b01;
        step();
        check("bp_wrong_vld",  {63'd0, rsp_valid}, 64'd1);
        check("bp_wrong_busy", {63'd0, busy}, 64'd1);
        check("bp_wrong_id",   {63'd0, rsp_id}, 64'd1);
        check("bp_wrong_rdy",  {62'd0, req_ready}, 64'd0);
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        check("bp_done_busy", {63'd0, busy}, 64'd0);
        check("bp_next_rdy",  {62'd0, req_ready}, 64'd1);
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b01;
        step(); step(); step();
        rsp_ready = 2'b00;

        // Reset during EXEC.
        req_a[63:32] = 32'd4; req_b[63:32] = 32'd4; req_op[7:4] = 4'b0010;
        req_valid = 2'b10;
        step();
        check("rexec_busy", {63'd0, busy}, 64'd1);
        req_valid = 2'b11;
        #2 reset = 1'b1;
        #1;
        check("rexec_busy0", {63'd0, busy}, 64'd0);
        check("rexec_vld",   {63'd0, rsp_valid}, 64'd0);
        check("rexec_rdy",   {62'd0, req_ready}, 64'd0);
        #3 reset = 1'b0;
        #1;
        check("rexec_first", {62'd0, req_ready}, 64'd1);
        req_valid = 2'b00;
        step();

        // Reset during RESP with a nonzero port-1 response.
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        check("rresp_vld1", {63'd0, rsp_valid}, 64'd1);
        check("rresp_res1", {32'd0, rsp_result}, 64'd8);
        #2 reset = 1'b1;
        #1;
        check("rresp_vld",  {63'd0, rsp_valid}, 64'd0);
        check("rresp_id",   {63'd0, rsp_id}, 64'd0);
        check("rresp_res",  {32'd0, rsp_result}, 64'd0);
        check("rresp_zero", {63'd0, rsp_zero}, 64'd0);
        check("rresp_busy", {63'd0, busy}, 64'd0);
        req_valid = 2'b11;
        #3 reset = 1'b0;
        #1;
        check("rresp_first", {62'd0, req_ready}, 64'd1);
        req_valid = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
`default_nettype wire
